cache_fill_ctrl: RTL
====================

// Module: cache_fill_ctrl
// PURPOSE
//  Memory-side responder for the I-cache and D-cache miss_detected interface.
//  Arbitrates both caches' block misses and D-cache write-through stores onto
//  the single pipelined main memory. Streams the returned words into the
//  missing cache's data array, then writes that cache's tag/valid.
//  Sits between cpu IF/MEM cache wrappers and the multicycle memory model.
// PARAMETERS
//  BLOCK_WORDS  8   16-bit words per cache block; power of 2, >=2
//  MEM_LAT      4   cycles from mem_en read issue to matching mem_rvalid
//  ADDR_W       16  byte-address width
//  DATA_W       16  word width
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       async active-low reset
//  i_miss       in   1       I-cache miss_detected; held until i_tag_we seen
//  i_miss_addr  in   ADDR_W  I-cache miss byte address
//  d_miss       in   1       D-cache load miss_detected; held until d_tag_we
//  d_miss_addr  in   ADDR_W  D-cache miss byte address
//  d_wr_req     in   1       write-through store request (stores never allocate)
//  d_wr_addr    in   ADDR_W  store byte address
//  d_wr_data    in   DATA_W  store data
//  d_wr_ack     out  1       store accepted and issued to memory this cycle
//  mem_en       out  1       memory access strobe
//  mem_wr       out  1       1=write, 0=read; valid with mem_en
//  mem_addr     out  ADDR_W  memory byte address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data
//  mem_rvalid   in   1       mem_rdata valid (one pulse per issued read)
//  fill_addr    out  ADDR_W  block-aligned address of block being filled
//  fill_word    out  log2(BLOCK_WORDS)  word offset of fill_data
//  fill_data    out  DATA_W  = mem_rdata (combinational)
//  i_fill_we    out  1       write fill_data into I-cache data array
//  d_fill_we    out  1       write fill_data into D-cache data array
//  i_tag_we     out  1       one-cycle pulse: write I-cache tag, set valid
//  d_tag_we     out  1       one-cycle pulse: write D-cache tag, set valid
//  i_fill_busy  out  1       controller currently owned by I-cache fill
//  d_fill_busy  out  1       controller currently owned by D-cache fill
// BEHAVIOUR
//  Reset: state IDLE, owner/counters 0, every output 0 except fill_data.
//  States: IDLE -> ISSUE -> WAIT -> TAG -> IDLE.
//  IDLE priority each cycle: d_miss > d_wr_req > i_miss.
//   d_miss/i_miss: latch owner, fill_addr = miss_addr with low
//     log2(BLOCK_WORDS)+1 bits cleared; next state ISSUE.
//   d_wr_req (no d_miss): same cycle mem_en=1, mem_wr=1, mem_addr=d_wr_addr,
//     mem_wdata=d_wr_data, d_wr_ack=1; stay IDLE. Stores: 1-cycle only.
//  ISSUE: BLOCK_WORDS cycles; cycle k: mem_en=1, mem_wr=0,
//   mem_addr=fill_addr+2k. Issue counter wraps to 0 -> WAIT.
//  ISSUE/WAIT: each mem_rvalid asserts owner's *_fill_we,
//   fill_word=receive count, then count++. Last word received -> TAG
//   (may occur in WAIT only, since MEM_LAT>=1).
//  TAG: one cycle, owner's *_tag_we=1, fill_addr still valid -> IDLE.
//  *_fill_busy = (state != IDLE) && owner matches.
//  Latency: miss seen in IDLE cycle 0 -> ISSUE 1..BLOCK_WORDS, words return
//   cycles 1+MEM_LAT..BLOCK_WORDS+MEM_LAT, TAG next cycle, IDLE after
//   (defaults: TAG cycle 13, new grant possible cycle 14).
//  Requests outside IDLE are not accepted (requester holds); no write ever
//   overlaps an in-flight read. Loser of simultaneous misses served next.
//  Miss dropped mid-fill: fill still completes, tag still written.
//  mem_rvalid in IDLE or TAG: ignored, no *_fill_we.
//  Reset mid-fill: immediate return to IDLE, no tag write; late mem_rvalid
//   ignored.
// TESTING
//  i_miss addr 0x0036, idle -> reads 0x0030..0x003E cycles 1-8, i_fill_we
//   words 0-7 cycles 5-12, i_tag_we cycle 13 only, i_fill_busy cycles 1-13.
//  i_miss and d_miss same cycle -> D filled first, I starts ISSUE the cycle
//   after d_tag_we.
//  d_wr_req 0x1000/0xBEEF in IDLE -> mem_en=1, mem_wr=1, d_wr_ack=1 same
//   cycle; d_wr_req during I fill -> no ack until IDLE.
//  d_wr_req with d_miss same cycle -> miss granted, store acked only after TAG.
//  Reset asserted in cycle 6 of fill -> outputs 0 async; rvalid cycles 7-12
//   produce no fill_we/tag_we; new i_miss after reset fills correctly.
//  Spurious mem_rvalid in IDLE -> no fill_we; back-to-back I misses with
//   BLOCK_WORDS=4, MEM_LAT=2 -> TAG cycle 7, correct fill_word sequence.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Block-fill and write-through controller shared by the I-cache and D-cache.
// Grants one requester at a time onto the pipelined main memory, streams the
// returned words into the owning cache's data array, then pulses its tag write.
module cache_fill_ctrl #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LAT     = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr_req,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [DATA_W-1:0]              d_wr_data,
  output logic                           d_wr_ack,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_rvalid,
  output logic [ADDR_W-1:0]              fill_addr,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]              fill_data,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic                           i_tag_we,
  output logic                           d_tag_we,
  output logic                           i_fill_busy,
  output logic                           d_fill_busy
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);

  // Byte address of a block: word offset bits plus the byte-in-word bit cleared.
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~((ADDR_W'(1) << (OFF_W + 1)) - ADDR_W'(1));
  localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_TAG   = 2'd3;

  // The last word can only return after issue finishes if memory takes >= 1 cycle.
  if (MEM_LAT < 1 || BLOCK_WORDS < 2 || (1 << OFF_W) != BLOCK_WORDS) begin : g_bad_params
    $error("cache_fill_ctrl: MEM_LAT must be >= 1 and BLOCK_WORDS a power of 2 >= 2");
  end

  logic [1:0]        state_q,     state_d;
  logic              owner_d_q,   owner_d_d;   // 1 = D-cache owns the fill
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [OFF_W-1:0]  issue_q,     issue_d;
  logic [OFF_W-1:0]  rcv_q,       rcv_d;
  logic              rx;

  // A returning word is accepted only while a fill is actually in flight.
  assign rx = mem_rvalid && (state_q == S_ISSUE || state_q == S_WAIT);

  // Arbitration, read issue and fill sequencing.
  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    fill_addr_d = fill_addr_q;
    issue_d     = issue_q;
    rcv_d       = rcv_q;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    d_wr_ack    = 1'b0;
    case (state_q)
      S_IDLE: begin
        issue_d = '0;
        rcv_d   = '0;
        if (d_miss) begin
          owner_d_d   = 1'b1;
          fill_addr_d = d_miss_addr & BLK_MASK;
          state_d     = S_ISSUE;
        end else if (d_wr_req) begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = d_wr_addr;
          mem_wdata = d_wr_data;
          d_wr_ack  = 1'b1;
        end else if (i_miss) begin
          owner_d_d   = 1'b0;
          fill_addr_d = i_miss_addr & BLK_MASK;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = fill_addr_q + (ADDR_W'(issue_q) << 1);
        issue_d  = issue_q + 1'b1;
        if (issue_q == LAST_WORD) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rx && rcv_q == LAST_WORD) state_d = S_TAG;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (rx) rcv_d = rcv_q + 1'b1;
  end

  // Controller state; reset abandons any fill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_d_q   <= 1'b0;
      fill_addr_q <= '0;
      issue_q     <= '0;
      rcv_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      fill_addr_q <= fill_addr_d;
      issue_q     <= issue_d;
      rcv_q       <= rcv_d;
    end
  end

  assign fill_addr   = fill_addr_q;
  assign fill_word   = rcv_q;
  assign fill_data   = mem_rdata;
  assign i_fill_we   = rx && !owner_d_q;
  assign d_fill_we   = rx &&  owner_d_q;
  assign i_tag_we    = (state_q == S_TAG) && !owner_d_q;
  assign d_tag_we    = (state_q == S_TAG) &&  owner_d_q;
  assign i_fill_busy = (state_q != S_IDLE) && !owner_d_q;
  assign d_fill_busy = (state_q != S_IDLE) &&  owner_d_q;

endmodule
